oled_seg_frame_gen: RTL and testbench

Upstream pixel source for the SSD1306 SPI display driver. Renders four hex digits as large seven-segment glyphs into a 128x64 frame and streams the 1024 frame bytes in horizontal-addressing order: page-major, column-minor, LSB = top pixel of each 8-row page. Output is a valid/ready byte stream that the driver consumes during its data phase.

---
 rtl/oled_seg_pkg.sv | 62 ++++++
 rtl/oled_seg_frame_gen_glyph.sv | 43 ++++
 rtl/oled_seg_frame_gen.sv | 145 ++++++++++++++
 tb/tb_oled_seg_frame_gen.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/oled_seg_pkg.sv
// Shared constants for the seven-segment frame generator: segment indices,
// glyph geometry, frame size, state encoding and the hex-to-segment decode.
package oled_seg_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam int              FRAME_BYTES = 1024;
  localparam int              IDX_W       = 10;
  localparam logic [IDX_W-1:0] LAST_IDX   = 10'(FRAME_BYTES - 1);

  // Cell-column bounds inside a 32-column digit cell
  localparam logic [4:0] MID_C_LO = 5'd8;
  localparam logic [4:0] MID_C_HI = 5'd23;
  localparam logic [4:0] RGT_C_LO = 5'd24;
  localparam logic [4:0] RGT_C_HI = 5'd27;
  localparam logic [4:0] LFT_C_LO = 5'd4;
  localparam logic [4:0] LFT_C_HI = 5'd7;
  localparam logic [4:0] DP_C_LO  = 5'd29;
  localparam logic [4:0] DP_C_HI  = 5'd30;

  localparam logic [2:0] PAGE_TOP   = 3'd0;
  localparam logic [2:0] PAGE_G_HI  = 3'd3;
  localparam logic [2:0] PAGE_G_LO  = 3'd4;
  localparam logic [2:0] PAGE_BOT   = 3'd7;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  // Returned vector is {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0:    seg = 7'b0111111;
      4'h1:    seg = 7'b0000110;
      4'h2:    seg = 7'b1011011;
      4'h3:    seg = 7'b1001111;
      4'h4:    seg = 7'b1100110;
      4'h5:    seg = 7'b1101101;
      4'h6:    seg = 7'b1111101;
      4'h7:    seg = 7'b0000111;
      4'h8:    seg = 7'b1111111;
      4'h9:    seg = 7'b1101111;
      4'hA:    seg = 7'b1110111;
      4'hB:    seg = 7'b1111100;
      4'hC:    seg = 7'b0111001;
      4'hD:    seg = 7'b1011110;
      4'hE:    seg = 7'b1111001;
      4'hF:    seg = 7'b1110001;
      default: seg = 7'b0000000;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/oled_seg_frame_gen_glyph.sv
// Combinational renderer: one frame byte (8 vertical pixels) of a digit cell
// at a given page and cell column.
module oled_seg_glyph_byte
  import oled_seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  input  logic [2:0] page,
  input  logic [4:0] cell_col,
  output logic [7:0] byte_o
);

  logic [6:0] seg_s;
  logic       in_mid_s;
  logic       in_rgt_s;
  logic       in_lft_s;
  logic       in_dp_s;
  logic       upper_s;
  logic [7:0] acc_s;

  // OR together every lit segment that covers this page/column
  always_comb begin
    seg_s    = hex_to_seg(nibble);
    in_mid_s = (cell_col >= MID_C_LO) && (cell_col <= MID_C_HI);
    in_rgt_s = (cell_col >= RGT_C_LO) && (cell_col <= RGT_C_HI);
    in_lft_s = (cell_col >= LFT_C_LO) && (cell_col <= LFT_C_HI);
    in_dp_s  = (cell_col >= DP_C_LO)  && (cell_col <= DP_C_HI);
    upper_s  = (page <= PAGE_G_HI);
    acc_s    = 8'h00;
    acc_s = acc_s | ((seg_s[SEG_A] && in_mid_s && (page == PAGE_TOP))  ? 8'h0F : 8'h00);
    acc_s = acc_s | ((seg_s[SEG_B] && in_rgt_s &&  upper_s)            ? 8'hFF : 8'h00);
    acc_s = acc_s | ((seg_s[SEG_C] && in_rgt_s && !upper_s)            ? 8'hFF : 8'h00);
    acc_s = acc_s | ((seg_s[SEG_D] && in_mid_s && (page == PAGE_BOT))  ? 8'hF0 : 8'h00);
    acc_s = acc_s | ((seg_s[SEG_E] && in_lft_s && !upper_s)            ? 8'hFF : 8'h00);
    acc_s = acc_s | ((seg_s[SEG_F] && in_lft_s &&  upper_s)            ? 8'hFF : 8'h00);
    acc_s = acc_s | ((seg_s[SEG_G] && in_mid_s && (page == PAGE_G_HI)) ? 8'hC0 : 8'h00);
    acc_s = acc_s | ((seg_s[SEG_G] && in_mid_s && (page == PAGE_G_LO)) ? 8'h03 : 8'h00);
    acc_s = acc_s | ((dp && in_dp_s && (page == PAGE_BOT))             ? 8'hC0 : 8'h00);
    byte_o = blank ? 8'h00 : acc_s;
  end

endmodule

// File: rtl/oled_seg_frame_gen.sv
// Streams a 128x64 frame of four seven-segment hex digits as 1024 bytes,
// page-major / column-minor, over a valid/ready interface.
module oled_seg_frame_gen
  import oled_seg_pkg::*;
#(
  parameter bit AUTO_REPEAT = 1'b0
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] digits,
  input  logic [3:0]  dp,
  input  logic [3:0]  blank,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      digits_q, digits_d;
  logic [3:0]       dp_q, dp_d;
  logic [3:0]       blank_q, blank_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             busy_q, busy_d;
  logic             load_s;
  logic             handshake_s;
  logic [1:0]       dsel_s;
  logic [3:0]       nibble_s;
  logic             glyph_dp_s;
  logic             glyph_blank_s;
  logic [7:0]       glyph_byte_s;

  assign handshake_s = out_valid_q & out_ready;

  // Next state, index and latched render inputs; load_s marks a new byte
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    digits_d    = digits_q;
    dp_d        = dp_q;
    blank_d     = blank_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    load_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          digits_d    = digits;
          dp_d        = dp;
          blank_d     = blank;
          idx_d       = '0;
          out_valid_d = 1'b1;
          busy_d      = 1'b1;
          load_s      = 1'b1;
          state_d     = ST_STREAM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (handshake_s && (idx_q == LAST_IDX)) begin
          if (AUTO_REPEAT) begin
            digits_d = digits;
            dp_d     = dp;
            blank_d  = blank;
            idx_d    = '0;
            load_s   = 1'b1;
          end else begin
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            state_d     = ST_IDLE;
          end
        end else if (handshake_s) begin
          idx_d  = idx_q + 10'd1;
          load_s = 1'b1;
        end else begin
          state_d = ST_STREAM;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // The glyph is rendered from the next index so the byte registers with it
  always_comb begin
    dsel_s        = idx_d[6:5];
    nibble_s      = digits_d[{dsel_s, 2'b00} +: 4];
    glyph_dp_s    = dp_d[dsel_s];
    glyph_blank_s = blank_d[dsel_s];
  end

  oled_seg_glyph_byte u_glyph (
    .nibble   (nibble_s),
    .dp       (glyph_dp_s),
    .blank    (glyph_blank_s),
    .page     (idx_d[9:7]),
    .cell_col (idx_d[4:0]),
    .byte_o   (glyph_byte_s)
  );

  always_comb begin
    out_data_d = load_s ? glyph_byte_s : out_data_q;
    out_last_d = out_valid_d && (idx_d == LAST_IDX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      digits_q    <= 16'h0000;
      dp_q        <= 4'h0;
      blank_q     <= 4'h0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      digits_q    <= digits_d;
      dp_q        <= dp_d;
      blank_q     <= blank_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_oled_seg_frame_gen.sv
// Directed bench for oled_seg_frame_gen: one single-shot instance and one
// AUTO_REPEAT instance, checked against a bench-side glyph model.
module tb_oled_seg_frame_gen;

  logic        clk = 1'b0;
  logic        rst, start, out_ready;
  logic [15:0] digits;
  logic [3:0]  dp, blank;
  logic [7:0]  out_data;
  logic        out_valid, out_last, busy;

  logic        rst2, start2;
  logic [15:0] digits2;
  logic [3:0]  dp2, blank2;
  logic [7:0]  out_data2;
  logic        out_valid2, out_last2, busy2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] cap     [1024];
  logic [7:0] ref_cap [1024];

  // {g,f,e,d,c,b,a} for hex 0..F
  logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  always #5 clk = ~clk;

  oled_seg_frame_gen #(.AUTO_REPEAT(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start), .digits(digits), .dp(dp), .blank(blank),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy)
  );

  oled_seg_frame_gen #(.AUTO_REPEAT(1'b1)) dut_rep (
    .clk(clk), .rst(rst2), .start(start2), .digits(digits2), .dp(dp2), .blank(blank2),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(1'b1),
    .out_last(out_last2), .busy(busy2)
  );

  function automatic logic [7:0] exp_byte(input logic [15:0] dg, input logic [3:0] dpv,
                                          input logic [3:0] bl, input int idx);
    int p, col, k, c;
    logic [6:0] s;
    logic [7:0] r;
    p   = idx / 128;
    col = idx % 128;
    k   = col / 32;
    c   = col % 32;
    r   = 8'h00;
    if (bl[k]) return 8'h00;
    s = seg_tbl[dg[4*k +: 4]];
    if (s[0] && p == 0 && c >= 8 && c <= 23)               r = r | 8'h0F;
    if (s[1] && p <= 3 && c >= 24 && c <= 27)              r = r | 8'hFF;
    if (s[2] && p >= 4 && c >= 24 && c <= 27)              r = r | 8'hFF;
    if (s[3] && p == 7 && c >= 8 && c <= 23)               r = r | 8'hF0;
    if (s[4] && p >= 4 && c >= 4 && c <= 7)                r = r | 8'hFF;
    if (s[5] && p <= 3 && c >= 4 && c <= 7)                r = r | 8'hFF;
    if (s[6] && p == 3 && c >= 8 && c <= 23)               r = r | 8'hC0;
    if (s[6] && p == 4 && c >= 8 && c <= 23)               r = r | 8'h03;
    if (dpv[k] && p == 7 && c >= 29 && c <= 30)            r = r | 8'hC0;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input logic [15:0] dg, input logic [3:0] dpv, input logic [3:0] bl);
    @(negedge clk);
    digits = dg;
    dp     = dpv;
    blank  = bl;
    start  = 1'b1;
    check("idle_before_start", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Consume a frame from the current negedge; optional mid-frame restart attempt or reset
  task automatic run_stream(input logic [15:0] dg, input logic [3:0] dpv, input logic [3:0] bl,
                            input bit bp, input int chg_at, input int abort_at);
    int n = 0;
    int cyc = 0;
    bit stall = 1'b0;
    bit chg_done = 1'b0;
    logic [7:0] prev_d = 8'h00;
    while (n < 1024 && cyc < 5000) begin
      check("valid", {31'd0, out_valid}, 32'd1);
      check("busy", {31'd0, busy}, 32'd1);
      check("data", {24'd0, out_data}, {24'd0, exp_byte(dg, dpv, bl, n)});
      check("last", {31'd0, out_last}, {31'd0, (n == 1023)});
      if (stall) check("stall_hold", {24'd0, out_data}, {24'd0, prev_d});
      if (n == abort_at) begin
        rst = 1'b1;
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_last", {31'd0, out_last}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      start = 1'b0;
      if (n == chg_at && !chg_done) begin
        start    = 1'b1;
        digits   = ~dg;
        blank    = ~bl;
        chg_done = 1'b1;
      end
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      stall  = !out_ready;
      prev_d = out_data;
      if (out_ready) begin
        cap[n] = out_data;
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("frame_len", n, 32'd1024);
    check("end_valid", {31'd0, out_valid}, 32'd0);
    check("end_busy", {31'd0, busy}, 32'd0);
    check("end_last", {31'd0, out_last}, 32'd0);
  endtask

  initial begin
    int diffs;
    int nz;
    int n;
    int cyc;
    rst = 1'b1; rst2 = 1'b1;
    start = 1'b0; start2 = 1'b0; out_ready = 1'b1;
    digits = 16'h0000; dp = 4'h0; blank = 4'h0;
    digits2 = 16'h0000; dp2 = 4'h0; blank2 = 4'h0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0; rst2 = 1'b0;

    // All-eights with decimal points, full-rate consumer
    start_frame(16'h8888, 4'hF, 4'h0);
    run_stream(16'h8888, 4'hF, 4'h0, 1'b0, -1, -1);
    check("e8_idx0",   {24'd0, cap[0]},   32'h00);
    check("e8_idx4",   {24'd0, cap[4]},   32'hFF);
    check("e8_idx8",   {24'd0, cap[8]},   32'h0F);
    check("e8_idx392", {24'd0, cap[392]}, 32'hC0);
    check("e8_idx520", {24'd0, cap[520]}, 32'h03);
    check("e8_idx904", {24'd0, cap[904]}, 32'hF0);
    check("e8_idx925", {24'd0, cap[925]}, 32'hC0);
    for (int i = 0; i < 1024; i++) ref_cap[i] = cap[i];

    // Digit0 = 1, digit1..3 = 0
    start_frame(16'h0001, 4'h0, 4'h0);
    run_stream(16'h0001, 4'h0, 4'h0, 1'b0, -1, -1);
    check("d1_idx4",   {24'd0, cap[4]},   32'h00);
    check("d1_idx8",   {24'd0, cap[8]},   32'h00);
    check("d1_idx24",  {24'd0, cap[24]},  32'hFF);
    check("d1_idx536", {24'd0, cap[536]}, 32'hFF);
    check("d0_idx40",  {24'd0, cap[40]},  32'h0F);
    check("d0_idx424", {24'd0, cap[424]}, 32'h00);

    // Random backpressure must reproduce the full-rate sequence
    start_frame(16'h8888, 4'hF, 4'h0);
    run_stream(16'h8888, 4'hF, 4'h0, 1'b1, -1, -1);
    diffs = 0;
    for (int i = 0; i < 1024; i++) if (cap[i] !== ref_cap[i]) diffs++;
    check("bp_seq_diffs", diffs, 32'd0);

    // Start pulse and input change mid-frame are ignored
    start_frame(16'h2A5C, 4'b0101, 4'h0);
    run_stream(16'h2A5C, 4'b0101, 4'h0, 1'b0, 300, -1);

    // Blank digit 0 on the next frame
    start_frame(16'h8888, 4'hF, 4'h1);
    run_stream(16'h8888, 4'hF, 4'h1, 1'b0, -1, -1);
    nz = 0;
    for (int i = 0; i < 1024; i++) if ((i % 128) < 32 && cap[i] !== 8'h00) nz++;
    check("blank_cell_nonzero", nz, 32'd0);

    // Asynchronous reset mid-frame, then a clean restart
    start_frame(16'h3F70, 4'h2, 4'h0);
    run_stream(16'h3F70, 4'h2, 4'h0, 1'b0, -1, 500);
    start_frame(16'h3F70, 4'h2, 4'h0);
    run_stream(16'h3F70, 4'h2, 4'h0, 1'b0, -1, -1);

    // Auto-repeat: back-to-back frames, new digits picked up at the wrap
    @(negedge clk);
    digits2 = 16'h8888; dp2 = 4'h0; blank2 = 4'h0; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    n = 0;
    cyc = 0;
    while (n < 1064 && cyc < 3000) begin
      check("rep_valid", {31'd0, out_valid2}, 32'd1);
      check("rep_busy", {31'd0, busy2}, 32'd1);
      if (n < 1024)
        check("rep_data_f0", {24'd0, out_data2}, {24'd0, exp_byte(16'h8888, 4'h0, 4'h0, n)});
      else
        check("rep_data_f1", {24'd0, out_data2}, {24'd0, exp_byte(16'h1111, 4'h0, 4'h0, n - 1024)});
      check("rep_last", {31'd0, out_last2}, {31'd0, (n == 1023)});
      if (n == 1000) digits2 = 16'h1111;
      n++;
      @(negedge clk);
      cyc++;
    end
    check("rep_len", n, 32'd1064);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
